// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipeline stage registers: stage-register state
// encoding, payload field widths, per-stage bundle widths and the NOP payload
// used when a stage is squashed to a bubble.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Payload field widths
  localparam int ALUOP_W   = 8;
  localparam int ALUSEL_W  = 3;
  localparam int REG_W     = 32;
  localparam int REGADDR_W = 5;

  // Per-stage bundle widths
  localparam int IF_ID_W  = 2 * REG_W;                                  // pc + inst
  localparam int ID_EX_W  = ALUOP_W + ALUSEL_W + 2 * REG_W + REGADDR_W + 1;
  localparam int EX_MEM_W = ALUOP_W + 2 * REG_W + REGADDR_W + 1;
  localparam int MEM_WB_W = REG_W + REGADDR_W + 1;

  localparam logic [ALUOP_W-1:0]  EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP = 3'b000;

  // ID/EX bubble: {aluop, alusel, opv1, opv2, waddr, wreg}
  localparam logic [ID_EX_W-1:0] ID_EX_NOP =
    {EXE_NOP_OP, EXE_RES_NOP, {REG_W{1'b0}}, {REG_W{1'b0}}, {REGADDR_W{1'b0}}, 1'b0};

endpackage

// File: rtl/pipe_data_reg.sv
// pipe_data_reg
// DATA_W payload register with load enable and optional synchronous clear.
// Ports:
//   clk  - clock, rising edge
//   clr  - synchronous clear (honoured only when CLEAR_DATA=1), wins over ld
//   ld   - load enable
//   d    - next payload
//   q    - held payload
module pipe_data_reg #(
  parameter int DATA_W     = 81,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ld,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  generate
    if (CLEAR_DATA != 0) begin : g_clr
      always_ff @(posedge clk) begin
        if (clr)     q <= '0;
        else if (ld) q <= d;
      end
    end else begin : g_noclr
      // No reset on the payload: only control state needs a known value.
      always_ff @(posedge clk) begin
        if (ld) q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Valid/ready pipeline stage register with flush, back-pressure and an
// optional second (skid) entry that keeps in_ready registered at full rate.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   flush            - synchronous squash, empties the stage
//   in_valid/ready   - upstream handshake, in_data payload
//   out_valid/ready  - downstream handshake, out_data from the main register
//   occ              - entries held (0..2)
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W     = ID_EX_W,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  state_t            state_p1;
  logic              in_xfer;
  logic              out_xfer;
  logic              main_ld;
  logic              skid_ld;
  logic              clr;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;

  assign in_xfer  = in_valid && in_ready && !flush;
  assign out_xfer = out_valid && out_ready;
  assign clr      = rst || flush;

  assign out_valid = (state_p1 != EMPTY);
  assign occ       = state_p1;

  generate
    if (SKID != 0) begin : g_rdy_reg
      assign in_ready = (state_p1 != TWO) && !rst;
    end else begin : g_rdy_comb
      assign in_ready = !rst && (!out_valid || out_ready);
    end
  endgenerate

  // Main takes the new beat when it is free or being drained at the same edge;
  // leaving TWO it refills from the skid entry to preserve order.
  assign main_ld = (in_xfer && (state_p1 == EMPTY || out_xfer)) ||
                   (state_p1 == TWO && out_xfer);
  assign main_d  = (state_p1 == TWO) ? skid_q : in_data;
  assign skid_ld = (state_p1 == ONE) && in_xfer && !out_xfer;

  // ---- stage p1: control state ----
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_p1 <= EMPTY;
    end else begin
      case (state_p1)
        EMPTY: if (in_xfer) state_p1 <= ONE;
        ONE: begin
          // With SKID=0, an input-only transfer from ONE cannot occur since
          // in_ready there requires out_ready.
          if (in_xfer && !out_xfer && SKID != 0) state_p1 <= TWO;
          else if (!in_xfer && out_xfer)         state_p1 <= EMPTY;
        end
        TWO:     if (out_xfer) state_p1 <= ONE;
        default: state_p1 <= EMPTY;
      endcase
    end
  end

  // ---- stage p1: payload registers ----
  pipe_data_reg #(
    .DATA_W    (DATA_W),
    .CLEAR_DATA(CLEAR_DATA)
  ) u_main (
    .clk(clk),
    .clr(clr),
    .ld (main_ld),
    .d  (main_d),
    .q  (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_data_reg #(
        .DATA_W    (DATA_W),
        .CLEAR_DATA(CLEAR_DATA)
      ) u_skid (
        .clk(clk),
        .clr(clr),
        .ld (skid_ld),
        .d  (in_data),
        .q  (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = '0;
    end
  endgenerate

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register that supersedes the fixed ID/EX latch. It carries an opaque payload between two pipeline stages under a valid/ready handshake, with:
- synchronous flush for branch/exception squash;
- downstream stall (back-pressure);
- an optional second skid entry, so that in_ready is registered and full throughput is kept.

It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB, with the stage payload packed into in_data.

## Interface
Parameters:
- DATA_W, 81 — payload width; default is the ID/EX bundle: aluop 8 + alusel 3 + opv1 32 + opv2 32 + waddr 5 + wreg 1.
- SKID, 1 — 1 selects the two-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.
- CLEAR_DATA, 1 — 1 zeroes the payload registers on rst/flush; 0 leaves payload registers without reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous squash; empties the stage.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload; always driven from the main register.
- occ  out  2  entries held, 0..2.

## Operation
- Handshakes:
  - Input transfer: in_valid && in_ready && !flush.
  - Output transfer: out_valid && out_ready.
- Two internal registers: main (drives out_data) and skid (used only when SKID=1).
- SKID=1 state machine; states EMPTY / ONE / TWO, with occ = 0 / 1 / 2:
  - EMPTY: input transfer -> main<=in_data, go to ONE.
  - ONE, input and output transfer -> main<=in_data, stay in ONE.
  - ONE, input only -> skid<=in_data, go to TWO.
  - ONE, output only -> go to EMPTY.
  - TWO: in_ready=0. Output transfer -> main<=skid, go to ONE.
- Outputs (SKID=1):
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO) && !rst, decoded from state flops only.
- SKID=0:
  - Single entry; occ ∈ {0,1}.
  - in_ready = !rst && (!out_valid || out_ready), combinational.
  - Input transfer loads main and sets out_valid.
  - Output transfer without input transfer clears out_valid.
- Flush:
  - Next state is EMPTY regardless of the handshakes.
  - A beat presented in the flush cycle is discarded, even if in_ready=1.
  - An output transfer in the flush cycle still counts as consumed downstream.
  - If CLEAR_DATA=1, main and skid are zeroed.
- rst has priority over flush. It has the same effect as flush, and additionally in_ready=0 while rst is asserted.
- Payload is never modified, reordered or duplicated. Order out equals order in.

## Timing
- Reset values (rst sampled high at an edge):
  - out_valid=0, occ=0, state EMPTY.
  - out_data=0 if CLEAR_DATA=1.
  - in_ready=0 while rst is high, and 1 in the first cycle after rst deasserts.
- Latency: an input transfer at edge N gives out_valid=1 and out_data=that beat in cycle N+1.
- Throughput: one beat per cycle while out_ready=1.
- Back-pressure response (SKID=1): with out_ready low, the stage absorbs two beats. in_ready falls the cycle after the second accepted beat and rises the cycle after the output transfer that leaves TWO.
- Back-pressure response (SKID=0): in_ready follows out_ready in the same cycle.
- Stall: out_valid and out_data are held stable until an output transfer occurs.
- Simultaneous input and output transfer in ONE: the new beat appears on the next cycle and occ stays 1.
- Flush and stall together: out_valid=0 in the next cycle.

## Structure
- Shared package pipe_pkg holds:
  - state encoding: EMPTY=2'd0, ONE=2'd1, TWO=2'd2;
  - payload field widths: ALUOP_W=8, ALUSEL_W=3, REG_W=32, REGADDR_W=5;
  - derived bundle widths per stage, e.g. ID_EX_W=81;
  - NOP payload constant: aluop EXE_NOP_OP, alusel EXE_RES_NOP, all other fields 0.
- Sub-module pipe_data_reg: a DATA_W register with load enable and optional synchronous clear. It is instantiated for main and for skid; the skid instance is generated only when SKID=1.

## Test plan
- Reset and flow: rst 2 cycles, then in_data=0x1..0x4 with in_valid=1 back-to-back and out_ready=1 -> out_data 0x1..0x4 on consecutive cycles, starting 1 cycle after the first accept; in_ready=0 only during rst.
- Stall fill (SKID=1): out_ready=0, offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, occ=2, in_ready=0, 0xC held upstream. Then out_ready=1 -> outputs 0xA, 0xB, 0xC in order, no loss.
- Flush in TWO with in_valid=1 carrying 0xD -> next cycle out_valid=0, occ=0, out_data=0 (CLEAR_DATA=1); 0xD never appears on the output.
- Flush with simultaneous output transfer of 0x5 -> 0x5 is counted as delivered exactly once; stage is empty next cycle.
- SKID=0 build: out_ready toggled 1,0,1,0 with a continuous input stream -> in_ready equals out_ready whenever out_valid=1; ordered delivery; occ never exceeds 1.
- Mid-operation reset while occ=2 -> next cycle occ=0, out_valid=0; first post-reset beat 0x7 emerges 1 cycle after its accept.
